// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter
//   Shares one single-port synchronous block RAM between a display reader,
//   a queued host writer and a full-memory fill sequencer.
//   Port priority per cycle: display read > queued host write > fill write.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   disp_req, disp_x, disp_y display read request and pixel coordinates
//   disp_valid, disp_data    read data, one cycle after disp_req
//   host_wr_*                valid/ready host write into the write queue
//   clear_start, clear_color request a fill of all 4096 blocks with a colour
//   clear_busy, clear_done   fill in progress / one-cycle completion pulse
//   mem_*                    RAM port (mem_rdata valid one cycle after a read)
module block_ram_arbiter #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [11:0]       host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [11:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t              state, state_next;

  logic [11:0]         fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                empty, full, push, pop;

  logic [11:0]         fill_cnt;
  logic [DATA_W-1:0]   color_q;
  logic                fill_we, color_load, clear_fin;

  logic [DATA_W-1:0]   disp_data_q;
  logic [11:0]         disp_addr;
  logic                unused_low;

  // 64 blocks per row of 16x16 pixels; the 6-bit fields cannot carry,
  // so the sum is already the 12-bit wrapped address.
  assign disp_addr  = {disp_y[9:4], 6'b0} + {6'b0, disp_x[9:4]};
  assign unused_low = ^{disp_x[3:0], disp_y[3:0]};

  assign empty         = (count == '0);
  assign full          = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign host_wr_ready = !full && (state == IDLE);
  assign push          = host_wr_valid && host_wr_ready;
  assign clear_busy    = (state != IDLE);

  // Read data is passed straight through in its valid cycle and held afterwards.
  assign disp_data = disp_valid ? mem_rdata : disp_data_q;

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    pop        = 1'b0;
    fill_we    = 1'b0;
    color_load = 1'b0;
    clear_fin  = 1'b0;

    // Port outputs are gated by rst so they sit at zero throughout reset.
    if (!rst) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (!empty && state != CLEAR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
        pop       = 1'b1;
      end else if (state == CLEAR) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fill_cnt;
        mem_wdata = color_q;
        fill_we   = 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (clear_start) begin
          state_next = DRAIN;
          color_load = 1'b1;
        end
      end
      DRAIN: begin
        // No pushes are accepted outside IDLE, so popping the last entry empties it.
        if (empty || (count == (PTR_W+1)'(1) && pop)) state_next = CLEAR;
      end
      CLEAR: begin
        if (fill_we && fill_cnt == '1) begin
          state_next = IDLE;
          clear_fin  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_wr_addr;
      fifo_data[wr_ptr] <= host_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fill_cnt    <= '0;
      color_q     <= '0;
      disp_valid  <= 1'b0;
      disp_data_q <= '0;
      clear_done  <= 1'b0;
    end else begin
      state      <= state_next;
      clear_done <= clear_fin;
      disp_valid <= disp_req;
      if (disp_valid) disp_data_q <= mem_rdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (color_load) begin
        color_q  <= clear_color;
        fill_cnt <= '0;
      end else if (fill_we) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb_block_ram_arbiter
//   Scoreboard bench for block_ram_arbiter. A behavioural RAM answers the
//   DUT's port; a reference model (queue of pending writes, occupancy count,
//   busy flag, shadow memory) predicts every port cycle and output.
module tb_block_ram_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [9:0]    disp_x, disp_y;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          host_wr_valid, host_wr_ready;
  logic [11:0]   host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy, clear_done;
  logic          mem_en, mem_we;
  logic [11:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  block_ram_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM seen by the DUT.
  logic [DW-1:0] ram [4096];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [11:0]   a;
    logic [DW-1:0] d;
    bit            fill;
  } wr_t;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  logic [DW-1:0] ref_mem [4096];
  wr_t           wq[$];
  logic [DW-1:0] rq[$];
  int            occ = 0;
  bit            model_busy = 0;
  bit            bubble = 0;
  bit            done_pend = 0;
  bit            prev_req = 0;
  logic [DW-1:0] last_data = '0;
  int            last_fill_addr = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] blk_addr(input int x, input int y);
    return 12'((y / 16) * 64 + (x / 16));
  endfunction

  // Monitor + model: checks this cycle's outputs, then advances the model
  // by what the coming rising edge will do.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      wq.delete();
      rq.delete();
      occ = 0;
      model_busy = 0;
      bubble = 0;
      done_pend = 0;
      prev_req = 0;
      last_data = '0;
    end else begin
      bit            exp_ready, exp_write, pop_host, push;
      logic [11:0]   a;
      wr_t           h;

      chk("disp_valid", disp_valid, prev_req);
      if (disp_valid) begin
        if (rq.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          last_data = rq.pop_front();
          chk("disp_data", disp_data, last_data);
        end
      end else begin
        chk("disp_data_hold", disp_data, last_data);
      end

      chk("clear_done", clear_done, done_pend);
      done_pend = 0;
      chk("clear_busy", clear_busy, model_busy);
      exp_ready = (occ < DEPTH) && !model_busy;
      chk("host_wr_ready", host_wr_ready, exp_ready);

      exp_write = !disp_req && wq.size() > 0 && !bubble;
      bubble = 0;
      pop_host = 0;
      if (disp_req) begin
        a = blk_addr(int'(disp_x), int'(disp_y));
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, a);
        rq.push_back(ref_mem[a]);
      end else if (exp_write) begin
        h = wq.pop_front();
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, h.a);
        chk("wr_mem_wdata", mem_wdata, h.d);
        ref_mem[h.a] = h.d;
        if (h.fill) begin
          last_fill_addr = int'(h.a);
          if (h.a == 12'hFFF) begin
            done_pend = 1;
            model_busy = 0;
          end
        end else begin
          pop_host = 1;
        end
      end else begin
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_we", mem_we, 0);
      end

      push = host_wr_valid && exp_ready;
      if (push) wq.push_back('{a: host_wr_addr, d: host_wr_data, fill: 0});
      occ = occ + int'(push) - int'(pop_host);

      if (clear_start && !model_busy) begin
        model_busy = 1;
        last_fill_addr = -1;
        // With nothing left to drain, one empty drain cycle precedes the fill.
        if (occ == 0) bubble = 1;
        for (int i = 0; i < 4096; i++) wq.push_back('{a: 12'(i), d: clear_color, fill: 1});
      end
      prev_req = disp_req;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_disp(input int pct);
    disp_req = ($urandom_range(99) < pct);
    disp_x   = 10'($urandom);
    disp_y   = 10'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst = 1; disp_req = 0; disp_x = 0; disp_y = 0;
    host_wr_valid = 0; host_wr_addr = 0; host_wr_data = 0;
    clear_start = 0; clear_color = 0;
    repeat (3) cyc();
    rst = 0;
    cyc();

    // Display address examples, including the far corner.
    disp_req = 1; disp_x = 10'd37; disp_y = 10'd50;
    #1 chk("addr_37_50", mem_addr, 12'h0C2);
    cyc();
    disp_x = 10'd1023; disp_y = 10'd1023;
    #1 chk("addr_1023_1023", mem_addr, 12'hFFF);
    cyc();
    disp_x = 10'd0; disp_y = 10'd1023;
    cyc();
    disp_req = 0;
    cyc();

    // Fill the queue while reads hold the port, then offer a fifth write.
    disp_req = 1; disp_x = 10'd100; disp_y = 10'd200;
    for (int i = 0; i < 5; i++) begin
      host_wr_valid = 1;
      host_wr_addr  = 12'h0C2 + 12'(i);
      host_wr_data  = 8'hA0 + 8'(i);
      cyc();
    end
    host_wr_valid = 0;
    #1 chk("ready_when_full", host_wr_ready, 0);
    cyc();
    disp_req = 0;
    repeat (6) cyc();
    // Read back the freshly written block.
    disp_req = 1; disp_x = 10'd37; disp_y = 10'd50;
    cyc();
    disp_req = 0;
    cyc();

    // Two queued writes, then a fill with colour 0x3C and interleaved reads.
    disp_req = 1;
    for (int i = 0; i < 2; i++) begin
      host_wr_valid = 1;
      host_wr_addr  = 12'($urandom);
      host_wr_data  = 8'($urandom);
      cyc();
    end
    host_wr_valid = 0;
    clear_start = 1; clear_color = 8'h3C;
    cyc();
    clear_start = 0;
    begin
      int guard = 0;
      while (model_busy && guard < 20000) begin
        rand_disp(30);
        host_wr_valid = $urandom_range(1);
        host_wr_addr  = 12'($urandom);
        host_wr_data  = 8'($urandom);
        clear_start   = (guard == 50);
        clear_color   = 8'hA5;
        cyc();
        guard++;
      end
      if (guard >= 20000) chk("fill_timeout", 1, 0);
    end
    clear_start = 0; host_wr_valid = 0; disp_req = 0;
    repeat (8) cyc();

    // Reset around fill counter 100.
    clear_start = 1; clear_color = 8'($urandom);
    cyc();
    clear_start = 0;
    begin
      int guard = 0;
      while (last_fill_addr < 99 && guard < 2000) begin
        rand_disp(20);
        cyc();
        guard++;
      end
      if (guard >= 2000) chk("fill100_timeout", 1, 0);
    end
    disp_req = 1;
    rst = 1;
    #1;
    chk("async_rst_mem_en", mem_en, 0);
    chk("async_rst_clear_busy", clear_busy, 0);
    chk("async_rst_disp_valid", disp_valid, 0);
    chk("async_rst_disp_data", disp_data, 0);
    disp_req = 0;
    repeat (2) cyc();
    rst = 0;
    #1 chk("ready_after_rst", host_wr_ready, 1);
    cyc();

    // Random traffic without fills.
    for (int i = 0; i < 400; i++) begin
      rand_disp(40);
      host_wr_valid = $urandom_range(1);
      host_wr_addr  = 12'($urandom_range(15));
      host_wr_data  = 8'($urandom);
      cyc();
    end
    host_wr_valid = 0; disp_req = 0;
    begin
      int guard = 0;
      while (wq.size() > 0 && guard < 100) begin
        cyc();
        guard++;
      end
      if (guard >= 100) chk("drain_timeout", 1, 0);
    end
    // Read back the small address range the random writes targeted.
    for (int i = 0; i < 16; i++) begin
      disp_req = 1; disp_x = 10'(i * 16); disp_y = 10'd0;
      cyc();
    end
    disp_req = 0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
